// File: rtl/patch_netlist_eval.sv
// patch_netlist_eval: evaluates a streamed netlist of 2-input gates on one
// latched primary-input vector and reports the value of the final gate.
// Optional feature: define EVAL_XOR_EN to enable XOR (op 2) and XNOR (op 3);
// without it those opcodes are rejected as unsupported and raise err.
module patch_netlist_eval #(
    parameter int NUM_PI    = 3,
    parameter int MAX_WIRES = 32,
    parameter int IDX_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_PI-1:0] pi_vec,
    input  logic              g_valid,
    output logic              g_ready,
    input  logic [1:0]        g_op,
    input  logic [IDX_W-1:0]  g_in0,
    input  logic [IDX_W-1:0]  g_in1,
    input  logic              g_inv0,
    input  logic              g_inv1,
    input  logic              g_last,
    output logic              out_valid,
    output logic              out_value,
    output logic [IDX_W-1:0]  out_wire_cnt,
    output logic              err
);

    localparam int PI_W = (NUM_PI > 1) ? $clog2(NUM_PI) : 1;
    localparam int WA_W = (MAX_WIRES > 1) ? $clog2(MAX_WIRES) : 1;
    localparam logic [IDX_W:0]   NUM_PI_X    = (IDX_W+1)'(NUM_PI);
    localparam logic [IDX_W-1:0] MAX_WIRES_X = IDX_W'(MAX_WIRES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                state, next_state;
    logic [NUM_PI-1:0]     pi_q;
    logic [MAX_WIRES-1:0]  wire_q;
    logic [IDX_W-1:0]      count;

    logic xfer, gate_err, op_bad, legal0, legal1, v0, v1, result;

    // Value of operand idx: a latched primary input or an already-evaluated wire.
    function automatic logic operand(input logic [IDX_W-1:0] idx,
                                     input logic [NUM_PI-1:0] pis,
                                     input logic [MAX_WIRES-1:0] ws);
        logic [IDX_W:0]  ext;
        logic [IDX_W:0]  woff;
        logic [PI_W-1:0] pi_idx;
        logic [WA_W-1:0] w_idx;
        ext    = {1'b0, idx};
        woff   = ext - NUM_PI_X;
        pi_idx = idx[PI_W-1:0];
        w_idx  = woff[WA_W-1:0];
        return (ext < NUM_PI_X) ? pis[pi_idx] : ws[w_idx];
    endfunction

    // Gate evaluation and legality of the record currently offered.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        xfer   = g_valid && (state == S_RUN);
        v0     = operand(g_in0, pi_q, wire_q) ^ g_inv0;
        v1     = operand(g_in1, pi_q, wire_q) ^ g_inv1;
        legal0 = {1'b0, g_in0} < (NUM_PI_X + {1'b0, count});
        legal1 = {1'b0, g_in1} < (NUM_PI_X + {1'b0, count});
        result = 1'b0;
        case (g_op)
            2'd0:    result = v0 & v1;
            2'd1:    result = v0 | v1;
            2'd2:    result = v0 ^ v1;
            default: result = ~(v0 ^ v1);
        endcase
`ifdef EVAL_XOR_EN
        op_bad = 1'b0;
`else
        op_bad = g_op[1];
`endif
        gate_err = !legal0 || !legal1 || (count == MAX_WIRES_X) || op_bad;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        next_state = state;
        g_ready    = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: if (start) next_state = S_RUN;
            S_RUN: begin
                g_ready = 1'b1;
                if (xfer) begin
                    if (gate_err)    next_state = S_ERR;
                    else if (g_last) next_state = S_DONE;
                end
            end
            S_DONE: begin
                out_valid  = 1'b1;
                next_state = S_IDLE;
            end
            default: if (start) next_state = S_RUN;
        endcase
    end

    // Datapath: latched inputs, wire store, gate counter, results and error flag.
    // NOTE: the wire store is a flat register vector, so it is cleared by reset
    // like any other flop; stale wires are never readable anyway because legality
    // only admits indices below the current count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_q         <= '0;
            wire_q       <= '0;
            count        <= '0;
            out_value    <= 1'b0;
            out_wire_cnt <= '0;
            err          <= 1'b0;
        end else begin
            if (start && (state == S_IDLE || state == S_ERR)) begin
                pi_q  <= pi_vec;
                count <= '0;
                err   <= 1'b0;
            end
            if (xfer) begin
                if (gate_err) begin
                    err <= 1'b1;
                end else begin
                    wire_q[count[WA_W-1:0]] <= result;
                    count                   <= count + IDX_W'(1);
                    if (g_last) begin
                        out_value    <= result;
                        out_wire_cnt <= count + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_patch_netlist_eval.sv
// Self-checking bench for patch_netlist_eval: a table of single-gate netlists
// plus directed multi-gate, error, overflow and mid-run reset sequences.
module tb_patch_netlist_eval;

    localparam int NUM_PI    = 3;
    localparam int MAX_WIRES = 32;
    localparam int IDX_W     = 6;
`ifdef EVAL_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [NUM_PI-1:0] pi_vec;
    logic              g_valid;
    logic              g_ready;
    logic [1:0]        g_op;
    logic [IDX_W-1:0]  g_in0;
    logic [IDX_W-1:0]  g_in1;
    logic              g_inv0;
    logic              g_inv1;
    logic              g_last;
    logic              out_valid;
    logic              out_value;
    logic [IDX_W-1:0]  out_wire_cnt;
    logic              err;

    patch_netlist_eval #(.NUM_PI(NUM_PI), .MAX_WIRES(MAX_WIRES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pi_vec(pi_vec),
        .g_valid(g_valid), .g_ready(g_ready), .g_op(g_op),
        .g_in0(g_in0), .g_in1(g_in1), .g_inv0(g_inv0), .g_inv1(g_inv1),
        .g_last(g_last), .out_valid(out_valid), .out_value(out_value),
        .out_wire_cnt(out_wire_cnt), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ov_total = 0;

    // Count every out_valid cycle so sequences can prove no result was emitted.
    always @(negedge clk) if (out_valid) ov_total++;

    typedef struct packed {
        logic [2:0] pi;
        logic [1:0] op;
        logic [5:0] in0;
        logic       inv0;
        logic [5:0] in1;
        logic       inv1;
        logic       exp_val;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] pv);
        @(negedge clk);
        pi_vec = pv;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_gate(input logic [1:0] op, input logic [5:0] i0, input logic n0,
                             input logic [5:0] i1, input logic n1, input logic last);
        @(negedge clk);
        g_op = op; g_in0 = i0; g_inv0 = n0; g_in1 = i1; g_inv1 = n1; g_last = last;
        g_valid = 1'b1;
        @(posedge clk);
        #1;
        g_valid = 1'b0;
        g_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        logic exp_err;

        // {pi, op, in0, inv0, in1, inv1, expected value}
        vecs[0] = '{3'b101, 2'd0, 6'd0, 1'b0, 6'd2, 1'b0, 1'b1};
        vecs[1] = '{3'b101, 2'd0, 6'd0, 1'b0, 6'd1, 1'b0, 1'b0};
        vecs[2] = '{3'b010, 2'd1, 6'd0, 1'b0, 6'd2, 1'b0, 1'b0};
        vecs[3] = '{3'b010, 2'd1, 6'd0, 1'b1, 6'd2, 1'b0, 1'b1};
        vecs[4] = '{3'b111, 2'd0, 6'd1, 1'b1, 6'd2, 1'b0, 1'b0};
        vecs[5] = '{3'b000, 2'd0, 6'd0, 1'b1, 6'd2, 1'b1, 1'b1};
        vecs[6] = '{3'b011, 2'd2, 6'd0, 1'b0, 6'd1, 1'b0, 1'b0};
        vecs[7] = '{3'b001, 2'd3, 6'd0, 1'b0, 6'd1, 1'b0, 1'b0};
        vecs[8] = '{3'b100, 2'd3, 6'd2, 1'b1, 6'd0, 1'b0, 1'b1};
        vecs[9] = '{3'b100, 2'd1, 6'd2, 1'b1, 6'd1, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; pi_vec = '0; g_valid = 1'b0; g_op = '0;
        g_in0 = '0; g_in1 = '0; g_inv0 = 1'b0; g_inv1 = 1'b0; g_last = 1'b0;
        #12;
        check("reset g_ready", 32'(g_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_value", 32'(out_value), 32'd0);
        check("reset out_wire_cnt", 32'(out_wire_cnt), 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle g_ready", 32'(g_ready), 32'd0);

        // Single-gate netlists from the table.
        for (int i = 0; i < 10; i++) begin
            exp_err = vecs[i].op[1] && !XOR_EN;
            do_start(vecs[i].pi);
            check($sformatf("vec%0d g_ready in run", i), 32'(g_ready), 32'd1);
            send_gate(vecs[i].op, vecs[i].in0, vecs[i].inv0, vecs[i].in1, vecs[i].inv1, 1'b1);
            if (exp_err) begin
                check($sformatf("vec%0d err", i), 32'(err), 32'd1);
                check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd0);
            end else begin
                check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
                check($sformatf("vec%0d out_value", i), 32'(out_value), 32'(vecs[i].exp_val));
                check($sformatf("vec%0d out_wire_cnt", i), 32'(out_wire_cnt), 32'd1);
                check($sformatf("vec%0d err", i), 32'(err), 32'd0);
            end
            tick();
            check($sformatf("vec%0d out_valid after", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d g_ready after", i), 32'(g_ready), 32'd0);
        end

        // Two-gate netlist with a wire operand, result 0, then output hold.
        do_start(3'b110);
        send_gate(2'd1, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0);
        check("seq2 g_ready mid", 32'(g_ready), 32'd1);
        send_gate(2'd0, 6'd3, 1'b0, 6'd0, 1'b0, 1'b1);
        check("seq2 out_valid", 32'(out_valid), 32'd1);
        check("seq2 out_value", 32'(out_value), 32'd0);
        check("seq2 out_wire_cnt", 32'(out_wire_cnt), 32'd2);
        check("seq2 g_ready done", 32'(g_ready), 32'd0);
        tick();
        check("seq2 g_ready next", 32'(g_ready), 32'd0);
        tick();
        check("seq2 hold cnt", 32'(out_wire_cnt), 32'd2);

        // Forward reference on the first gate, then start clears err.
        snap = ov_total;
        do_start(3'b111);
        send_gate(2'd0, 6'd3, 1'b0, 6'd0, 1'b0, 1'b1);
        check("fwd err", 32'(err), 32'd1);
        check("fwd g_ready", 32'(g_ready), 32'd0);
        tick();
        tick();
        check("fwd no out_valid", 32'(ov_total - snap), 32'd0);
        check("fwd err sticky", 32'(err), 32'd1);
        do_start(3'b111);
        check("fwd start clears err", 32'(err), 32'd0);
        check("fwd restart g_ready", 32'(g_ready), 32'd1);
        send_gate(2'd0, 6'd0, 1'b0, 6'd1, 1'b0, 1'b1);
        check("fwd recover value", 32'(out_value), 32'd1);
        tick();

        // Overflow: 33 back-to-back gates, no g_last.
        snap = ov_total;
        do_start(3'b001);
        for (int i = 0; i < MAX_WIRES + 1; i++) begin
            send_gate(2'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
            check($sformatf("ovf err after gate %0d", i + 1), 32'(err),
                  (i == MAX_WIRES) ? 32'd1 : 32'd0);
        end
        tick();
        check("ovf no out_valid", 32'(ov_total - snap), 32'd0);
        check("ovf g_ready", 32'(g_ready), 32'd0);

        // Reference two-gate netlist, result 1 (from ERR via start).
        do_start(3'b001);
        send_gate(2'd0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b0);
        send_gate(2'd1, 6'd3, 1'b1, 6'd1, 1'b0, 1'b1);
        check("seq1 out_valid", 32'(out_valid), 32'd1);
        check("seq1 out_value", 32'(out_value), 32'd1);
        check("seq1 out_wire_cnt", 32'(out_wire_cnt), 32'd2);
        tick();
        check("seq1 pulse one cycle", 32'(out_valid), 32'd0);

        // Reset asserted mid-run after 5 gates.
        do_start(3'b111);
        for (int i = 0; i < 5; i++) send_gate(2'd1, 6'd0, 1'b0, 6'd1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst g_ready", 32'(g_ready), 32'd0);
        check("mrst out_valid", 32'(out_valid), 32'd0);
        check("mrst out_value", 32'(out_value), 32'd0);
        check("mrst out_wire_cnt", 32'(out_wire_cnt), 32'd0);
        check("mrst err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mrst g_ready idle 1", 32'(g_ready), 32'd0);
        tick();
        check("mrst g_ready idle 2", 32'(g_ready), 32'd0);
        do_start(3'b000);
        check("mrst g_ready after start", 32'(g_ready), 32'd1);
        send_gate(2'd0, 6'd0, 1'b1, 6'd1, 1'b1, 1'b1);
        check("mrst new run value", 32'(out_value), 32'd1);
        check("mrst new run cnt", 32'(out_wire_cnt), 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
